div_seq: RTL and testbench

- Iterative restoring divider for the tiny processor datapath; sits beside the ALU and provides the inverse of its multiply unit.
- Takes accumulator and source operands, computes quotient and remainder over N_BIT cycles, and signals completion with a start/busy/done handshake.
- Signed/unsigned selection mirrors the multiplier's mul_type; result segment select mirrors mul_seg_sel (quotient or remainder onto one result bus).

---
 rtl/div_seq.sv | 187 ++++++++++++++++++
 tb/tb_div_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for the tiny processor datapath.
// Computes quotient and remainder of dividend_in / divisor_in over N_BIT
// cycles, signed or unsigned, with a start/busy/done handshake.
// Ports:
//   clk_in, rst_in        clock (rising edge), async active-high reset
//   start_in              request, sampled only when idle
//   div_type_in           0 = unsigned, 1 = signed (latched with start)
//   seg_sel_in            selects res_out: 0 = quotient, 1 = remainder
//   dividend_in           accumulator operand (latched with start)
//   divisor_in            source operand (latched with start)
//   busy_out              high from the cycle after accept until done falls
//   done_out              one-cycle completion pulse
//   div_by_zero_out       divisor was zero in the last operation
//   quot_out, rem_out     registered quotient / remainder
//   res_out               combinational select of quot_out / rem_out
module div_seq #(
    parameter int unsigned N_BIT = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             div_type_in,
    input  logic             seg_sel_in,
    input  logic [N_BIT-1:0] dividend_in,
    input  logic [N_BIT-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             div_by_zero_out,
    output logic [N_BIT-1:0] quot_out,
    output logic [N_BIT-1:0] rem_out,
    output logic [N_BIT-1:0] res_out
);

    localparam int unsigned CNT_W = (N_BIT > 1) ? $clog2(N_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_BIT-1:0]   dvd_q, dvd_d;       // dividend shift register, fills with quotient bits
    logic [N_BIT-1:0]   prem_q, prem_d;     // partial remainder
    logic [N_BIT-1:0]   dvs_q, dvs_d;       // divisor magnitude
    logic [N_BIT-1:0]   odvd_q, odvd_d;     // raw dividend, returned on divide by zero
    logic               dvd_neg_q, dvd_neg_d;
    logic               dvs_neg_q, dvs_neg_d;
    logic               dvs_zero_q, dvs_zero_d;
    logic [N_BIT-1:0]   quot_q, quot_d;
    logic [N_BIT-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand sign/magnitude at accept time; negation of the most negative
    // value yields the same bit pattern, read as an unsigned magnitude.
    logic               in_dvd_neg;
    logic               in_dvs_neg;
    logic [N_BIT-1:0]   in_dvd_mag;
    logic [N_BIT-1:0]   in_dvs_mag;

    assign in_dvd_neg = div_type_in & dividend_in[N_BIT-1];
    assign in_dvs_neg = div_type_in & divisor_in[N_BIT-1];
    assign in_dvd_mag = in_dvd_neg ? -dividend_in : dividend_in;
    assign in_dvs_mag = in_dvs_neg ? -divisor_in  : divisor_in;

    // One restoring step. Since prem < divisor, the shifted remainder minus
    // the divisor fits in N_BIT+1 signed bits, so its MSB is the borrow.
    logic [N_BIT:0]     rem_sh;
    logic [N_BIT:0]     trial;
    logic               borrow;

    assign rem_sh = {prem_q, dvd_q[N_BIT-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    assign borrow = trial[N_BIT];

    // State and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            prem_q     <= '0;
            dvs_q      <= '0;
            odvd_q     <= '0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            prem_q     <= prem_d;
            dvs_q      <= dvs_d;
            odvd_q     <= odvd_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            dvs_zero_q <= dvs_zero_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        prem_d     = prem_q;
        dvs_d      = dvs_q;
        odvd_d     = odvd_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        dvs_zero_d = dvs_zero_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_in) begin
                    odvd_d     = dividend_in;
                    dvd_neg_d  = in_dvd_neg;
                    dvs_neg_d  = in_dvs_neg;
                    dvd_d      = in_dvd_mag;
                    dvs_d      = in_dvs_mag;
                    dvs_zero_d = (divisor_in == '0);
                    prem_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                prem_d = borrow ? rem_sh[N_BIT-1:0] : trial[N_BIT-1:0];
                dvd_d  = {dvd_q[N_BIT-2:0], ~borrow};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_BIT - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide by zero wins over sign correction
                if (dvs_zero_q) begin
                    quot_d = '1;
                    rem_d  = odvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = (dvd_neg_q ^ dvs_neg_q) ? -dvd_q : dvd_q;
                    rem_d  = dvd_neg_q ? -prem_q : prem_q;
                    dbz_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign div_by_zero_out = dbz_q;
    assign quot_out        = quot_q;
    assign rem_out         = rem_q;
    assign res_out         = seg_sel_in ? rem_q : quot_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq with a cycle-level result model
// and a negedge compare process, plus literal expectations per vector.
module tb_div_seq;

    localparam int unsigned N = 8;

    logic         clk_in      = 1'b0;
    logic         rst_in      = 1'b1;
    logic         start_in    = 1'b0;
    logic         div_type_in = 1'b0;
    logic         seg_sel_in  = 1'b0;
    logic [N-1:0] dividend_in = '0;
    logic [N-1:0] divisor_in  = '0;
    logic         busy_out;
    logic         done_out;
    logic         div_by_zero_out;
    logic [N-1:0] quot_out;
    logic [N-1:0] rem_out;
    logic [N-1:0] res_out;

    int n_checks = 0;
    int n_errors = 0;

    div_seq #(.N_BIT(N)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .div_type_in     (div_type_in),
        .seg_sel_in      (seg_sel_in),
        .dividend_in     (dividend_in),
        .divisor_in      (divisor_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .div_by_zero_out (div_by_zero_out),
        .quot_out        (quot_out),
        .rem_out         (rem_out),
        .res_out         (res_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division straight from integer arithmetic
    function automatic void model_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic t,
                                      output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        int ai;
        int bi;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            if (t) begin
                ai = int'($signed(a));
                bi = int'($signed(b));
            end else begin
                ai = int'({24'd0, a});
                bi = int'({24'd0, b});
            end
            q = N'(ai / bi);
            r = N'(ai % bi);
            z = 1'b0;
        end
    endfunction

    // Timeline model: accept edge counts as 1, results + done after edge N+2,
    // back to idle after edge N+3 (start ignored on that edge).
    logic         m_active = 1'b0;
    int           m_edges  = 0;
    logic [N-1:0] pend_q   = '0;
    logic [N-1:0] pend_r   = '0;
    logic         pend_z   = 1'b0;
    logic [N-1:0] exp_q    = '0;
    logic [N-1:0] exp_r    = '0;
    logic         exp_z    = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_active = 1'b0;
            m_edges  = 0;
            exp_q    = '0;
            exp_r    = '0;
            exp_z    = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else if (!m_active) begin
            if (start_in) begin
                model_div(dividend_in, divisor_in, div_type_in, pend_q, pend_r, pend_z);
                m_active = 1'b1;
                m_edges  = 1;
                exp_busy = 1'b1;
            end
        end else begin
            m_edges++;
            if (m_edges == int'(N) + 2) begin
                exp_q    = pend_q;
                exp_r    = pend_r;
                exp_z    = pend_z;
                exp_done = 1'b1;
            end else if (m_edges == int'(N) + 3) begin
                m_active = 1'b0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end
        end
    end

    // Compare every cycle against the model
    always @(negedge clk_in) begin
        check("busy_out", 32'(busy_out), 32'(exp_busy));
        check("done_out", 32'(done_out), 32'(exp_done));
        check("div_by_zero_out", 32'(div_by_zero_out), 32'(exp_z));
        check("quot_out", 32'(quot_out), 32'(exp_q));
        check("rem_out", 32'(rem_out), 32'(exp_r));
        check("res_out", 32'(res_out), 32'(seg_sel_in ? exp_r : exp_q));
    end

    // One operation with literal expectations, latency and res_out mux checks
    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic t, input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic ez);
        logic [N-1:0] mq;
        logic [N-1:0] mr;
        logic         mz;
        int           edges;
        model_div(a, b, t, mq, mr, mz);
        check({name, " model quot"}, 32'(mq), 32'(eq));
        check({name, " model rem"}, 32'(mr), 32'(er));
        check({name, " model dbz"}, 32'(mz), 32'(ez));
        @(posedge clk_in); #1;
        dividend_in = a;
        divisor_in  = b;
        div_type_in = t;
        start_in    = 1'b1;
        @(posedge clk_in); #1;
        start_in    = 1'b0;
        dividend_in = ~a;
        divisor_in  = b + N'(1);
        div_type_in = ~t;
        edges = 1;
        while (done_out !== 1'b1 && edges < 40) begin
            @(posedge clk_in); #1;
            edges++;
            seg_sel_in = ~seg_sel_in;
        end
        check({name, " latency"}, 32'(edges), 32'(N + 2));
        check({name, " quot_out"}, 32'(quot_out), 32'(eq));
        check({name, " rem_out"}, 32'(rem_out), 32'(er));
        check({name, " dbz"}, 32'(div_by_zero_out), 32'(ez));
        seg_sel_in = 1'b0; #1;
        check({name, " res_out quot"}, 32'(res_out), 32'(eq));
        seg_sel_in = 1'b1; #1;
        check({name, " res_out rem"}, 32'(res_out), 32'(er));
        @(posedge clk_in); #1;
        check({name, " idle after done"}, 32'(busy_out), 32'(0));
    endtask

    logic [N-1:0] hs_a [6] = '{8'd100, 8'hF9, 8'h80, 8'd13, 8'd255, 8'd42};
    logic [N-1:0] hs_b [6] = '{8'd7,   8'd2,  8'hFF, 8'd0,  8'd16,  8'd5};

    initial begin
        int dones;
        #1;
        check("reset busy", 32'(busy_out), 32'(0));
        check("reset done", 32'(done_out), 32'(0));
        check("reset quot", 32'(quot_out), 32'(0));
        check("reset rem", 32'(rem_out), 32'(0));
        check("reset dbz", 32'(div_by_zero_out), 32'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        run_op("u 200/7",      8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0);
        run_op("u F9/02",      8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0);
        run_op("s -7/2",       8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
        run_op("s ovf 80/FF",  8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        run_op("u 2A/0",       8'h2A, 8'h00, 1'b0, 8'hFF, 8'h2A, 1'b1);
        run_op("s 2A/0",       8'h2A, 8'h00, 1'b1, 8'hFF, 8'h2A, 1'b1);
        run_op("s 100/-7",     8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0);
        run_op("s -128/3",     8'h80, 8'h03, 1'b1, 8'hD6, 8'hFE, 1'b0);
        run_op("u FF/01",      8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0);
        run_op("u 80/80",      8'h80, 8'h80, 1'b0, 8'h01, 8'h00, 1'b0);

        // start held high with operands changing every cycle
        @(posedge clk_in); #1;
        start_in    = 1'b1;
        div_type_in = 1'b1;
        dividend_in = hs_a[0];
        divisor_in  = hs_b[0];
        dones = 0;
        for (int i = 1; i <= 3 * (int'(N) + 3); i++) begin
            @(posedge clk_in); #1;
            if (done_out === 1'b1) dones++;
            dividend_in = hs_a[i % 6];
            divisor_in  = hs_b[i % 6];
            div_type_in = i[0];
        end
        start_in = 1'b0;
        check("back-to-back done count", 32'(dones), 32'(3));
        repeat (int'(N) + 4) @(posedge clk_in);
        #1;

        // reset in the middle of the calculation
        @(posedge clk_in); #1;
        dividend_in = 8'hC8;
        divisor_in  = 8'h07;
        div_type_in = 1'b0;
        start_in    = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("mid reset busy", 32'(busy_out), 32'(0));
        check("mid reset done", 32'(done_out), 32'(0));
        check("mid reset quot", 32'(quot_out), 32'(0));
        check("mid reset rem", 32'(rem_out), 32'(0));
        check("mid reset res", 32'(res_out), 32'(0));
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b0;
        repeat (int'(N) + 4) @(posedge clk_in);
        #1;
        check("no done after reset", 32'(quot_out), 32'(0));

        run_op("after reset 200/7", 8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0);

        repeat (2) @(posedge clk_in);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
